lfsr8_checker: RTL and testbench

Receive-side companion to the team's 8-bit Fibonacci LFSR generator (polynomial x^8+x^6+x^5+x^4+1, one-bit shift per clock). It consumes the generator's parallel 8-bit word stream, self-synchronises its own reference register from the data, and then predicts and compares every following word. It reports lock status, per-word error pulses, a saturating error count and loss-of-sync events. It sits at the far end of a link or loopback path under test in BIST and bring-up.

---
 rtl/lfsr8_pkg.sv | 31 +++
 rtl/lfsr8_err_count.sv | 35 +++
 rtl/lfsr8_checker.sv | 140 ++++++++++++++
 tb/tb_lfsr8_checker.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr8_pkg.sv
// Shared definitions for the 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1).
// Generator and checker both use lfsr8_step so there is one polynomial definition.
package lfsr8_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } state_t;

  // Feedback taps s[7], s[5], s[4], s[3].
  localparam logic [7:0] TAP_MASK    = 8'hB8;
  // All-zero word never leaves itself; the checker refuses to seed from it.
  localparam logic [7:0] LOCKUP_WORD = 8'h00;

  // One-bit Fibonacci shift: new LSB is the XOR of the tapped bits.
  function automatic logic [7:0] lfsr8_step(input logic [7:0] s);
    return {s[6:0], ^(s & TAP_MASK)};
  endfunction

  // Number of set bits in a byte (0..8).
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/lfsr8_err_count.sv
// Saturating error counter: clear beats increment, increment amount is 1..8.
module lfsr8_err_count #(
  parameter int CNT_W = 16
) (
  input  logic             MCLK,
  input  logic             MRST_N,
  input  logic             inc_en,
  input  logic [3:0]       inc_amt,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W+3:0] MAX_EXT = {4'd0, {CNT_W{1'b1}}};

  logic [CNT_W+3:0] sum;
  logic [CNT_W-1:0] cnt_d;

  // Add in a widened domain so a multi-bit step clamps at all-ones instead of wrapping.
  always_comb begin
    sum   = {4'd0, cnt} + {{CNT_W{1'b0}}, inc_amt};
    cnt_d = cnt;
    if (clr) begin
      cnt_d = '0;
    end else if (inc_en) begin
      cnt_d = (sum > MAX_EXT) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end
  end

  // Count register.
  always_ff @(posedge MCLK or negedge MRST_N) begin
    if (!MRST_N) cnt <= '0;
    else         cnt <= cnt_d;
  end

endmodule

// File: rtl/lfsr8_checker.sv
// Receive-side LFSR checker: self-synchronises on the incoming word stream,
// then flywheels its reference and flags every mismatching word.
// Optional build macro: LFSR8_CHK_BITERR_EN -- when defined ERR_CNT counts bit
// errors (popcount of the difference), otherwise it counts word errors.
//
// Input handshake: DIN is consumed on a rising MCLK edge only when DIN_VALID
// is high; there is no back-pressure. With DIN_VALID low every piece of
// state holds and no pulse is generated.
module lfsr8_checker
  import lfsr8_pkg::*;
#(
  parameter int LOCK_GOOD   = 4,
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 16
) (
  input  logic             MCLK,
  input  logic             MRST_N,
  input  logic             DIN_VALID,
  input  logic [7:0]       DIN,
  input  logic             CLR_CNT,
  output logic             LOCKED,
  output logic             ERR_PULSE,
  output logic             SYNC_LOSS,
  output logic [CNT_W-1:0] ERR_CNT,
  output state_t           fsm_state
);

  localparam logic [3:0] LOCK_GOOD_C   = 4'(LOCK_GOOD);
  localparam logic [3:0] LOSS_THRESH_C = 4'(LOSS_THRESH);

  state_t     state_q, state_d;
  logic [7:0] ref_q, ref_d;
  logic [3:0] good_q, good_d;
  logic [3:0] miss_q, miss_d;
  logic       pulse_d, loss_d;
  logic       inc_en;
  logic [3:0] inc_amt;
  logic [7:0] expected;

  assign expected  = lfsr8_step(ref_q);
  assign fsm_state = state_q;

  // Next-state, reference update and pulse decisions for one accepted word.
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    good_d  = good_q;
    miss_d  = miss_q;
    pulse_d = 1'b0;
    loss_d  = 1'b0;
    inc_en  = 1'b0;
`ifdef LFSR8_CHK_BITERR_EN
    inc_amt = popcount8(DIN ^ expected);
`else
    inc_amt = 4'd1;
`endif
    if (DIN_VALID) begin
      case (state_q)
        ST_HUNT: begin
          if (DIN != LOCKUP_WORD) begin
            ref_d   = DIN;
            good_d  = 4'd0;
            state_d = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (DIN == expected) begin
            ref_d = DIN;
            if (good_q + 4'd1 == LOCK_GOOD_C) begin
              good_d  = 4'd0;
              miss_d  = 4'd0;
              state_d = ST_LOCK;
            end else begin
              good_d = good_q + 4'd1;
            end
          end else if (DIN != LOCKUP_WORD) begin
            // Treat the mismatching word as a fresh seed.
            ref_d  = DIN;
            good_d = 4'd0;
          end else begin
            good_d  = 4'd0;
            state_d = ST_HUNT;
          end
        end
        ST_LOCK: begin
          // Flywheel: advance on every word so one bad word costs one error.
          ref_d = expected;
          if (DIN == expected) begin
            miss_d = 4'd0;
          end else begin
            pulse_d = 1'b1;
            inc_en  = 1'b1;
            if (miss_q + 4'd1 == LOSS_THRESH_C) begin
              loss_d  = 1'b1;
              miss_d  = 4'd0;
              good_d  = 4'd0;
              state_d = ST_HUNT;
            end else begin
              miss_d = miss_q + 4'd1;
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end
  end

  // State, reference and registered status outputs.
  always_ff @(posedge MCLK or negedge MRST_N) begin
    if (!MRST_N) begin
      state_q   <= ST_HUNT;
      ref_q     <= LOCKUP_WORD;
      good_q    <= 4'd0;
      miss_q    <= 4'd0;
      LOCKED    <= 1'b0;
      ERR_PULSE <= 1'b0;
      SYNC_LOSS <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      LOCKED    <= (state_d == ST_LOCK);
      ERR_PULSE <= pulse_d;
      SYNC_LOSS <= loss_d;
    end
  end

  lfsr8_err_count #(.CNT_W(CNT_W)) u_err_count (
    .MCLK    (MCLK),
    .MRST_N  (MRST_N),
    .inc_en  (inc_en),
    .inc_amt (inc_amt),
    .clr     (CLR_CNT),
    .cnt     (ERR_CNT)
  );

endmodule

// File: tb/tb_lfsr8_checker.sv
// Bench for lfsr8_checker: a wide-counter and a 4-bit-counter instance share
// one directed stimulus stream and are compared every cycle with a model.
module tb_lfsr8_checker;
  import lfsr8_pkg::*;

  localparam int LOCK_GOOD   = 4;
  localparam int LOSS_THRESH = 3;
`ifdef LFSR8_CHK_BITERR_EN
  localparam int BITERR = 1;
`else
  localparam int BITERR = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       din_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic       clr_cnt = 1'b0;

  logic        locked_w, pulse_w, loss_w;
  logic [15:0] cnt_w;
  state_t      st_w;
  logic        locked_n, pulse_n, loss_n;
  logic [3:0]  cnt_n;
  state_t      st_n;

  lfsr8_checker #(.LOCK_GOOD(LOCK_GOOD), .LOSS_THRESH(LOSS_THRESH), .CNT_W(16)) dut (
    .MCLK(clk), .MRST_N(rst_n), .DIN_VALID(din_valid), .DIN(din), .CLR_CNT(clr_cnt),
    .LOCKED(locked_w), .ERR_PULSE(pulse_w), .SYNC_LOSS(loss_w), .ERR_CNT(cnt_w),
    .fsm_state(st_w)
  );

  lfsr8_checker #(.LOCK_GOOD(LOCK_GOOD), .LOSS_THRESH(LOSS_THRESH), .CNT_W(4)) dut_s (
    .MCLK(clk), .MRST_N(rst_n), .DIN_VALID(din_valid), .DIN(din), .CLR_CNT(clr_cnt),
    .LOCKED(locked_n), .ERR_PULSE(pulse_n), .SYNC_LOSS(loss_n), .ERR_CNT(cnt_n),
    .fsm_state(st_n)
  );

  // ---------------- scoring ----------------
  int check_cnt = 0;
  int pass_cnt  = 0;

  task automatic check(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Next LFSR word by arithmetic: double modulo 256, plus parity of taps 7,5,4,3.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    int v;
    v = (int'(s) * 2) % 256 + ($countones(s & 8'hB8) % 2);
    return v[7:0];
  endfunction

  int         m_mode;     // 0 searching, 1 confirming, 2 locked
  logic [7:0] m_ref;
  int         m_good, m_miss;
  int         m_locked, m_pulse, m_loss;
  int         m_cnt_w, m_cnt_n;

  task automatic model_reset();
    m_mode = 0; m_ref = 8'h00; m_good = 0; m_miss = 0;
    m_locked = 0; m_pulse = 0; m_loss = 0; m_cnt_w = 0; m_cnt_n = 0;
  endtask

  task automatic model_clock();
    logic [7:0] want;
    int inc;
    inc = 0; m_pulse = 0; m_loss = 0;
    want = lfsr_next(m_ref);
    if (din_valid) begin
      if (m_mode == 0) begin
        if (din != 8'h00) begin m_ref = din; m_good = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (din == want) begin
          m_ref = din; m_good++;
          if (m_good == LOCK_GOOD) begin m_mode = 2; m_miss = 0; m_good = 0; end
        end else if (din != 8'h00) begin
          m_ref = din; m_good = 0;
        end else begin
          m_mode = 0; m_good = 0;
        end
      end else begin
        m_ref = want;
        if (din == want) m_miss = 0;
        else begin
          m_pulse = 1; m_miss++;
          inc = (BITERR != 0) ? $countones(din ^ want) : 1;
          if (m_miss == LOSS_THRESH) begin m_loss = 1; m_mode = 0; m_miss = 0; end
        end
      end
    end
    if (clr_cnt) begin
      m_cnt_w = 0; m_cnt_n = 0;
    end else begin
      m_cnt_w = (m_cnt_w + inc > 65535) ? 65535 : m_cnt_w + inc;
      m_cnt_n = (m_cnt_n + inc > 15) ? 15 : m_cnt_n + inc;
    end
    m_locked = (m_mode == 2) ? 1 : 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_clock();
    end
  end

  // Every-cycle comparison, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("locked",      int'(locked_w), m_locked);
      check("err_pulse",   int'(pulse_w),  m_pulse);
      check("sync_loss",   int'(loss_w),   m_loss);
      check("err_cnt",     int'(cnt_w),    m_cnt_w);
      check("locked_s",    int'(locked_n), m_locked);
      check("err_pulse_s", int'(pulse_n),  m_pulse);
      check("sync_loss_s", int'(loss_n),   m_loss);
      check("err_cnt_s",   int'(cnt_n),    m_cnt_n);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    din_valid = 1'b1; din = d; clr_cnt = 1'b0;
  endtask

  task automatic send_clr(input logic [7:0] d);
    @(negedge clk);
    din_valid = 1'b1; din = d; clr_cnt = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din_valid = 1'b0; din = 8'h00; clr_cnt = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    din_valid = 1'b0; clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
  endtask

  task automatic send_seed();
    send(8'h01); send(8'h02); send(8'h04); send(8'h08); send(8'h11);
  endtask

  // ---------------- directed scenarios ----------------
  logic [7:0] w;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_locked", int'(locked_w), 0);
    check("rst_cnt",    int'(cnt_w), 0);
    check("rst_state",  int'(st_w), int'(ST_HUNT));
    #2 rst_n = 1'b1;

    // Lock acquisition from the seed stream.
    send(8'h01); send(8'h02); send(8'h04); send(8'h08);
    idle(1);
    check("pre_lock", int'(locked_w), 0);
    send(8'h11);
    idle(1);
    check("lock_acq", int'(locked_w), 1);
    check("lock_cnt", int'(cnt_w), 0);

    // Single bad word (0x00 in place of 0x23); flywheel keeps 0x47 matching.
    send(8'h00);
    send(8'h47);
    check("single_pulse", int'(pulse_w), 1);
    idle(1);
    check("single_nopulse", int'(pulse_w), 0);
    check("single_locked", int'(locked_w), 1);
    check("single_cnt", int'(cnt_w), (BITERR != 0) ? 3 : 1);

    // Sync loss after three consecutive wrong words.
    pulse_clr();
    send(8'hFF); send(8'hFF); send(8'hFF);
    idle(1);
    check("loss_pulse",  int'(pulse_w), 1);
    check("loss_sync",   int'(loss_w), 1);
    check("loss_locked", int'(locked_w), 0);
    check("loss_cnt",    int'(cnt_w), (BITERR != 0) ? 14 : 3);

    // Lock-up word is ignored in hunt; gapped stream still locks cleanly.
    send(8'h00); send(8'h00); send(8'h00);
    idle(1);
    check("lockup_locked", int'(locked_w), 0);
    check("lockup_state",  int'(st_w), int'(ST_HUNT));
    send(8'h01); idle(1); send(8'h02); idle(1); send(8'h04); idle(1);
    send(8'h08); idle(1); send(8'h11); idle(1);
    check("gap_locked", int'(locked_w), 1);
    check("gap_cnt",    int'(cnt_w), (BITERR != 0) ? 14 : 3);

    // Saturation: 20 errors interleaved with good words so sync is kept.
    pulse_clr();
    w = 8'h11;
    for (int i = 0; i < 20; i++) begin
      w = lfsr_next(w); send(~w);
      w = lfsr_next(w); send(w);
    end
    idle(1);
    check("sat_small", int'(cnt_n), 15);
    check("sat_wide",  int'(cnt_w), (BITERR != 0) ? 160 : 20);
    check("sat_locked", int'(locked_w), 1);

    // Clear on the same cycle as an error: count goes to 0, pulse still fires.
    w = lfsr_next(w); send_clr(~w);
    idle(1);
    check("clr_pulse", int'(pulse_w), 1);
    check("clr_cnt",   int'(cnt_w), 0);
    check("clr_cnt_s", int'(cnt_n), 0);

    // Two errors, then reset in the middle of lock.
    w = lfsr_next(w); send(~w);
    w = lfsr_next(w); send(w);
    w = lfsr_next(w); send(~w);
    w = lfsr_next(w); send(w);
    idle(1);
    check("pre_rst_cnt", int'(cnt_w), (BITERR != 0) ? 16 : 2);
    check("pre_rst_locked", int'(locked_w), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_locked", int'(locked_w), 0);
    check("mid_rst_pulse",  int'(pulse_w), 0);
    check("mid_rst_loss",   int'(loss_w), 0);
    check("mid_rst_cnt",    int'(cnt_w), 0);
    check("mid_rst_state",  int'(st_w), int'(ST_HUNT));
    @(negedge clk);
    #2 rst_n = 1'b1;
    send_seed();
    idle(1);
    check("relock", int'(locked_w), 1);
    check("relock_cnt", int'(cnt_w), 0);
    idle(2);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
